// File: rtl/spi_ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_arb_pkg
// Shared definitions for the SPI / local-host configuration RAM arbiter:
//   - arb_state_e : arbiter FSM states (IDLE, ACCESS, RDWAIT)
//   - ADDR_W_DEF / DATA_W_DEF : default RAM geometry
//   - PORT_SPI / PORT_LOCAL : requester id encoding used for the winner and
//     round-robin pointer registers
//   - other_port() : the port that lost an arbitration won by the given port
// -----------------------------------------------------------------------------
package spi_ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  // Port ids are a single bit so they can index per-port vectors directly.
  localparam logic PORT_SPI   = 1'b0;
  localparam logic PORT_LOCAL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2
  } arb_state_e;

  function automatic logic other_port(input logic port_id);
    return (port_id == PORT_SPI) ? PORT_LOCAL : PORT_SPI;
  endfunction

endpackage : spi_ram_arb_pkg

// File: rtl/arb_rr_pick.sv
// -----------------------------------------------------------------------------
// arb_rr_pick
// Combinational two-way winner selection for spi_ram_arbiter.
//   req0, req1 : in  requests from port 0 (SPI) and port 1 (local host)
//   rr         : in  round-robin pointer, the preferred port on contention
//   winner     : out selected port id (only meaningful when any_req=1)
//   any_req    : out at least one request present
// Build option ARB_FIXED_PRIO_EN: when defined, rr is ignored and port 0
// always wins contention (port 1 can starve under sustained SPI traffic).
// -----------------------------------------------------------------------------
module arb_rr_pick
  import spi_ram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr,
  output logic winner,
  output logic any_req
);

  assign any_req = req0 | req1;

`ifdef ARB_FIXED_PRIO_EN
  // The pointer is not part of the decision in this build.
  logic unused_rr;
  assign unused_rr = rr;

  always_comb begin
    winner = PORT_SPI;
    if (!req0 && req1) begin
      winner = PORT_LOCAL;
    end
  end
`else
  always_comb begin
    winner = PORT_SPI;
    if (req0 && req1) begin
      // Contention: the pointer names the port whose turn it is.
      winner = rr;
    end else if (req1) begin
      winner = PORT_LOCAL;
    end
  end
`endif

endmodule : arb_rr_pick

// File: rtl/spi_ram_arbiter.sv
// -----------------------------------------------------------------------------
// spi_ram_arbiter
// Shares one single-port configuration RAM between the SPI slave command path
// (port 0) and the local register/host requester (port 1). Each port issues
// single-byte reads or writes with a req/gnt/rvalid handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN    request side of port N (held until gntN)
//   gntN                     one-cycle pulse when the access is issued to RAM
//   rvalidN                  one-cycle pulse when rdata carries port N's read
//   rdata                    shared read data, holds last completed read
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata  RAM strobes and data
//   busy                     FSM outside IDLE
//
// Timing: request seen in IDLE at cycle N -> ACCESS (gnt, ram_en) at N+1 ->
// writes back in IDLE at N+2; reads sit in RDWAIT at N+2 capturing ram_rdata,
// and rvalid appears at N+3 together with the next arbitration slot.
//
// Build option ARB_FIXED_PRIO_EN: fixed priority to port 0, pointer frozen.
// -----------------------------------------------------------------------------
module spi_ram_arbiter
  import spi_ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,

  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,

  output logic [DATA_W-1:0] rdata,

  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,

  output logic              busy
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e        state_q, state_d;
  logic              winner_q, winner_d;   // owner of the in-flight access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rr_q, rr_d;           // port preferred on contention
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rvalid_q, rvalid_d;   // indexed by port id

  logic              pick_winner;
  logic              pick_any;

  arb_rr_pick u_pick (
    .req0    (req0),
    .req1    (req1),
    .rr      (rr_q),
    .winner  (pick_winner),
    .any_req (pick_any)
  );

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rr_d     = rr_q;
    rdata_d  = rdata_q;
    rvalid_d = 2'b00;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          // Latch the whole transaction so the requester may drop req
          // without affecting the access already decided.
          winner_d = pick_winner;
          if (pick_winner == PORT_LOCAL) begin
            we_d    = we1;
            addr_d  = addr1;
            wdata_d = wdata1;
          end else begin
            we_d    = we0;
            addr_d  = addr0;
            wdata_d = wdata0;
          end
`ifndef ARB_FIXED_PRIO_EN
          // Pointer moves at decision time, to the port that did not win,
          // whether or not that port was actually requesting.
          rr_d = other_port(pick_winner);
`endif
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        ram_en = 1'b1;
        ram_we = we_q;
        gnt0   = (winner_q == PORT_SPI);
        gnt1   = (winner_q == PORT_LOCAL);
        state_d = we_q ? ST_IDLE : ST_RDWAIT;
      end

      ST_RDWAIT: begin
        // RAM output is valid now; register it so rdata is stable for the
        // whole rvalid cycle and afterwards until the next read completes.
        rdata_d            = ram_rdata;
        rvalid_d[winner_q] = 1'b1;
        state_d            = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      winner_q <= PORT_SPI;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rr_q     <= PORT_SPI;
      rdata_q  <= '0;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rr_q     <= rr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Address and write data come straight from the latched transaction, so
  // they hold their last value between accesses.
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign rvalid0   = rvalid_q[PORT_SPI];
  assign rvalid1   = rvalid_q[PORT_LOCAL];
  assign busy      = (state_q != ST_IDLE);

endmodule : spi_ram_arbiter

// File: tb/tb_spi_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_arbiter
// Self-checking bench for spi_ram_arbiter. A transaction-level model schedules
// what every output must be on each future cycle when an arbitration decision
// is made; a negedge process compares all DUT outputs against it each cycle.
// Directed scenarios add literal expectations; a randomized phase follows.
// Honors ARB_FIXED_PRIO_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_spi_ram_arbiter;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       busy;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  // Synchronous single-port RAM attached to the arbiter.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  int checks = 0;
  int failures = 0;
  int ncyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, ncyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: per-cycle expectation slots filled at decision time.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         g0, g1, en, we, rv0, rv1, acc, rvev;
    logic [7:0] addr, wdata, rdata;
  } slot_t;

  slot_t      slots [8];
  logic [7:0] shadow [256];
  logic [7:0] cur_addr, cur_wdata, cur_rdata;
  int         free_cycle = 0;
  bit         pref = 1'b0;
  bit         check_en = 1'b0;
  bit         verbose = 1'b1;

  // Observations for directed scenarios.
  int         g_port_q[$];
  int         g_cyc_q[$];
  bit         lg[2];
  int         lg_cyc;
  bit         lg_we;
  logic [7:0] lg_addr;
  bit         lrv[2];
  logic [7:0] lrv_data;
  int         lrv_cyc;
  int         en_cnt = 0;
  int         rv1_cnt = 0;

  always @(negedge clk) begin : monitor
    int    si, ns, rs;
    slot_t s;
    bit    w, wew;
    logic [7:0] a, d;
    si = ncyc % 8;
    s  = slots[si];
    if (check_en) begin
      if (s.acc)  begin cur_addr = s.addr; cur_wdata = s.wdata; end
      if (s.rvev) cur_rdata = s.rdata;
      chk("gnt0", gnt0, s.g0);
      chk("gnt1", gnt1, s.g1);
      chk("ram_en", ram_en, s.en);
      chk("ram_we", ram_we, s.we);
      chk("rvalid0", rvalid0, s.rv0);
      chk("rvalid1", rvalid1, s.rv1);
      chk("busy", busy, (ncyc < free_cycle));
      chk("ram_addr", ram_addr, cur_addr);
      chk("ram_wdata", ram_wdata, cur_wdata);
      chk("rdata", rdata, cur_rdata);
    end
    lg[0] = gnt0; lg[1] = gnt1;
    lrv[0] = rvalid0; lrv[1] = rvalid1;
    if (gnt0 || gnt1) begin
      g_port_q.push_back(gnt1 ? 1 : 0);
      g_cyc_q.push_back(ncyc);
      lg_cyc = ncyc; lg_we = ram_we; lg_addr = ram_addr;
      if (verbose)
        $display("TXN gnt  cycle=%0d port=%0d we=%0d addr=%02h wdata=%02h",
                 ncyc, gnt1, ram_we, ram_addr, ram_wdata);
    end
    if (rvalid0 || rvalid1) begin
      lrv_data = rdata; lrv_cyc = ncyc;
      if (verbose)
        $display("TXN read cycle=%0d port=%0d rdata=%02h", ncyc, rvalid1, rdata);
    end
    if (ram_en) en_cnt++;
    if (rvalid1) rv1_cnt++;

    slots[si] = '{default: 0};
    if (rst) begin
      for (int i = 0; i < 8; i++) slots[i] = '{default: 0};
      cur_addr = 8'h00; cur_wdata = 8'h00; cur_rdata = 8'h00;
      pref = 1'b0;
      free_cycle = ncyc + 1;
      check_en = 1'b1;
    end else if (check_en && ncyc >= free_cycle && (req0 || req1)) begin
      if (req0 && req1) w = FIXED ? 1'b0 : pref;
      else              w = req1;
      if (!FIXED) pref = ~w;
      wew = w ? we1 : we0;
      a   = w ? addr1 : addr0;
      d   = w ? wdata1 : wdata0;
      ns  = (ncyc + 1) % 8;
      slots[ns].g0 = !w; slots[ns].g1 = w;
      slots[ns].en = 1'b1; slots[ns].we = wew;
      slots[ns].acc = 1'b1; slots[ns].addr = a; slots[ns].wdata = d;
      if (wew) begin
        shadow[a]  = d;
        free_cycle = ncyc + 2;
      end else begin
        rs = (ncyc + 3) % 8;
        slots[rs].rv0 = !w; slots[rs].rv1 = w;
        slots[rs].rvev = 1'b1; slots[rs].rdata = shadow[a];
        free_cycle = ncyc + 3;
      end
    end
    ncyc++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit r, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  task automatic set_req(input int p, input bit r);
    if (p == 0) req0 = r; else req1 = r;
  endtask

  // Issue one transaction, wait (bounded) for its grant, then optionally drop req.
  task automatic txn(input int p, input bit we, input logic [7:0] a, input logic [7:0] d,
                     input bit drop, output int gcyc);
    bit got = 1'b0;
    gcyc = -1;
    drive(p, 1'b1, we, a, d);
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (lg[p]) begin got = 1'b1; gcyc = lg_cyc; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL txn_gnt_timeout port=%0d actual=none required=gnt", p);
    end
    if (drop) set_req(p, 1'b0);
  endtask

  task automatic wait_rv(input int p, output logic [7:0] d, output int c);
    bit got = 1'b0;
    d = 8'hxx; c = -1;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (lrv[p]) begin got = 1'b1; d = lrv_data; c = lrv_cyc; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL rvalid_timeout port=%0d actual=none required=rvalid", p);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int g1, g2, rc, n0, n1, e0, r0;
    logic [7:0] d;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; shadow[i] = 8'h00; end
    ram_rdata = 8'h00;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(2);
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_ram_addr", ram_addr, 8'h00);

    // Both ports hold continuous reads: 6 grants.
    g_port_q.delete();
    drive(0, 1'b1, 1'b0, 8'h01, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h02, 8'h00);
    for (int i = 0; i < 60 && g_port_q.size() < 6; i++) tick();
    set_req(0, 1'b0); set_req(1, 1'b0);
    idle(4);
    begin
      int exp_seq [6];
      exp_seq = FIXED ? '{0, 0, 0, 0, 0, 0} : '{0, 1, 0, 1, 0, 1};
      chk("alt_count", (g_port_q.size() >= 6), 1'b1);
      for (int i = 0; i < 6 && i < g_port_q.size(); i++)
        chk($sformatf("alt_grant%0d", i), g_port_q[i], exp_seq[i]);
    end

    // Port 0 write 0x12=A5, port 1 read back.
    txn(0, 1'b1, 8'h12, 8'hA5, 1'b1, g1);
    chk("wr_ram_we", lg_we, 1'b1);
    chk("wr_ram_addr", lg_addr, 8'h12);
    tick();
    txn(1, 1'b0, 8'h12, 8'h00, 1'b1, g1);
    wait_rv(1, d, rc);
    chk("rd_rdata", d, 8'hA5);
    chk("rd_latency", rc - g1, 2);
    idle(2);

    // req1 pulsed only during port 0's ACCESS cycle: ignored.
    g_port_q.delete();
    e0 = en_cnt;
    drive(0, 1'b1, 1'b1, 8'h20, 8'h11);
    tick();                          // decision cycle
    set_req(0, 1'b0);
    drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();                          // ACCESS cycle for port 0
    set_req(1, 1'b0);
    idle(5);
    n0 = 0; n1 = 0;
    foreach (g_port_q[i]) if (g_port_q[i] == 1) n1++; else n0++;
    chk("pulse_gnt0", n0, 1);
    chk("pulse_no_gnt1", n1, 0);
    chk("pulse_ram_acc", en_cnt - e0, 1);

    // Port 1 read of 0x40 (holds 0x3C) killed by reset in RDWAIT.
    txn(1, 1'b1, 8'h40, 8'h3C, 1'b1, g1);
    tick();
    txn(1, 1'b0, 8'h40, 8'h00, 1'b1, g1);
    r0 = rv1_cnt;
    rst = 1'b1;                      // asserted during RDWAIT
    tick();
    rst = 1'b0;
    idle(4);
    chk("rst_rd_no_rvalid1", rv1_cnt - r0, 0);
    chk("rst_rd_rdata", rdata, 8'h00);

    // Move the pointer to port 1, reset during an ACCESS, then contend.
    txn(0, 1'b1, 8'h05, 8'h77, 1'b1, g1);
    tick();
    drive(0, 1'b1, 1'b1, 8'h06, 8'h78);
    tick();                          // decision
    set_req(0, 1'b0);
    rst = 1'b1;                      // ACCESS cycle
    tick();
    rst = 1'b0;
    g_port_q.delete();
    drive(0, 1'b1, 1'b0, 8'h05, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h06, 8'h00);
    for (int i = 0; i < 20 && g_port_q.size() < 1; i++) tick();
    set_req(0, 1'b0); set_req(1, 1'b0);
    idle(4);
    chk("rst_rr_first", (g_port_q.size() > 0) ? g_port_q[0] : -1, 0);

    // Back-to-back writes at the address boundaries, then read back.
    txn(0, 1'b1, 8'h00, 8'h5A, 1'b0, g1);
    txn(0, 1'b1, 8'hFF, 8'hC3, 1'b1, g2);
    chk("b2b_spacing", g2 - g1, 2);
    tick();
    txn(0, 1'b0, 8'h00, 8'h00, 1'b1, g1);
    wait_rv(0, d, rc);
    chk("b2b_rd00", d, 8'h5A);
    txn(0, 1'b0, 8'hFF, 8'h00, 1'b1, g1);
    wait_rv(0, d, rc);
    chk("b2b_rdFF", d, 8'hC3);
    idle(2);

    // Randomized traffic, occasional abandonment and resets.
    for (int c = 0; c < 2500; c++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < 2; p++) begin
        bit cur_req;
        cur_req = (p == 0) ? req0 : req1;
        if (lg[p] || !cur_req) begin
          if ($urandom_range(0, 99) < (lg[p] ? 30 : 35)) begin
            int k;
            logic [7:0] a;
            k = $urandom_range(0, 9);
            a = (k == 8) ? 8'hFF : (k == 9) ? 8'h80 : 8'(k);
            drive(p, 1'b1, 1'($urandom_range(0, 1)), a, 8'($urandom));
          end else begin
            set_req(p, 1'b0);
          end
        end else if ($urandom_range(0, 99) < 4) begin
          set_req(p, 1'b0);
        end
      end
    end
    rst = 1'b0;
    set_req(0, 1'b0); set_req(1, 1'b0);
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_spi_ram_arbiter

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Two-port arbiter that shares the single-port 8-bit configuration RAM between the SPI slave command path (port 0) and a local register/host requester (port 1). Each requester issues single-byte read or write transactions over a req/gnt/rvalid handshake. The arbiter sequences every access into the RAM's enable/write/address strobes and returns read data to the owning port. It sits between the SPI slave front end and the RAM instance, replacing the direct rx_valid/tx_valid coupling.

## Interface
- ADDR_W, 8, RAM address width (depth = 2**ADDR_W)
- DATA_W, 8, RAM data width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, held until gnt
- we0 / we1  in  1  1 = write, 0 = read; valid while req high
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle pulse: access issued to RAM
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata valid (reads only)
- rdata  out  DATA_W  read data, shared by both ports, qualified by rvalid
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable (meaningful with ram_en)
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE: if any req is high, pick winner, latch winner id, we, addr, wdata into internal registers; go to ACCESS. Else stay.
- ACCESS: drive ram_en=1, ram_we/addr/wdata from latched registers; pulse gnt of winner. If write, go to IDLE. If read, go to RDWAIT.
- RDWAIT: register ram_rdata into rdata; go to IDLE. rvalid of winner pulses the following cycle (registered).
- Round-robin: priority pointer rr. Both requesting: rr selects winner. After every grant rr points to the loser. Single request: granted regardless of rr.
- rr updates on the arbitration decision in IDLE, not on completion.
- req deasserted before arbitration: no access, no gnt. req deasserted after latching: access still completes.
- Requester must drop req (or present a new transaction) the cycle after gnt; req still high after gnt is a new request.
- ram_en, ram_we low in IDLE and RDWAIT; ram_addr/ram_wdata hold last value.
- rdata holds the last read value until the next read completes.

## Timing
- Reset values: state IDLE, rr=0 (port 0 first), gnt0/gnt1/rvalid0/rvalid1/ram_en/ram_we/busy=0, ram_addr/ram_wdata/rdata=0.
- req seen high in IDLE at cycle N -> ACCESS at N+1 (gnt, ram_en high) -> write completes, IDLE at N+2.
- Read: RDWAIT at N+2 (rdata captured end of cycle), rvalid high at N+3, coinciding with IDLE of next arbitration.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Reset asserted mid-transaction: next cycle all outputs at reset values, in-flight read dropped, no rvalid emitted, rr=0.
- gnt and rvalid never high on both ports in the same cycle.

## Configuration
- ARB_FIXED_PRIO_EN defined: rr ignored and not updated; port 0 (SPI) always wins when both request. Port 1 may starve.
- Not defined: round-robin as above.

## Structure
- Package spi_ram_arb_pkg: FSM state type (IDLE, ACCESS, RDWAIT), default ADDR_W/DATA_W constants, port-id encoding (PORT_SPI=0, PORT_LOCAL=1).
- One sub-module: arb_rr_pick (two req in, rr in, winner out, combinational), holds the ARB_FIXED_PRIO_EN selection.

## Test plan
- Reset: assert rst 2 cycles -> all outputs 0, busy=0, next simultaneous req0/req1 grants port 0 first.
- Port 0 write addr=0x12 data=0xA5, then port 1 read addr=0x12 -> gnt0 at N+1 with ram_we=1; gnt1 then rvalid1 two cycles later with rdata=0xA5.
- Both ports hold continuous read requests for 6 grants -> gnts alternate 0,1,0,1,0,1; with ARB_FIXED_PRIO_EN all 6 go to port 0.
- req1 pulsed one cycle while FSM in ACCESS for port 0 -> no gnt1, no RAM access for port 1.
- Port 1 read of addr 0x40 (holds 0x3C), rst asserted in RDWAIT -> no rvalid1, rdata=0x00, rr=0.
- Back-to-back port 0 writes to addr 0x00 and 0xFF (address boundary) then reads -> data returned correctly, write spacing exactly 2 cycles.
